// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data RAM arbiter.
package mem_arb_pkg;

  typedef enum logic {PORT_I, PORT_D} mem_port_t;

  typedef enum logic {IDLE, RD_WAIT} arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter: bit 0 is the instruction port, bit 1 the data port.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       prefer,
  output logic [1:0] gnt,
  output logic       next_prefer
);

  always_comb begin
    gnt[0] = req[0] & (~req[1] | ~prefer);
    gnt[1] = req[1] & (~req[0] | prefer);

    // Point the preference at whichever port lost (or sat out) this cycle.
    next_prefer = prefer;
    if (gnt[0]) begin
      next_prefer = 1'b1;
    end else if (gnt[1]) begin
      next_prefer = 1'b0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous-read RAM between instruction fetch and load/store.
// Grants are combinational; read data returns on the owner's rvalid one cycle later.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [31:0]           i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [WIDTH-1:0]      i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [31:0]           d_addr,
  input  logic [WIDTH-1:0]      d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [WIDTH-1:0]      d_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [WIDTH-1:0]      ram_wdata,
  output logic                  ram_wren,
  input  logic [WIDTH-1:0]      ram_rdata
);

  arb_state_t state_q, state_d;
  mem_port_t  owner_q, owner_d;
  logic       prefer_q, prefer_d;
  logic [1:0] req, gnt;
  logic       rd_grant;
  logic       unused_addr_bits;

  // Requests are masked in reset so no grant or write can escape.
  assign req = {d_req & rst, i_req & rst};

  rr_arbiter2 u_rr_arbiter2 (
    .req         (req),
    .prefer      (prefer_q),
    .gnt         (gnt),
    .next_prefer (prefer_d)
  );

  assign i_gnt    = gnt[0];
  assign d_gnt    = gnt[1];
  assign rd_grant = gnt[0] | (gnt[1] & ~d_we);

  assign ram_addr  = gnt[0] ? i_addr[ADDR_WIDTH+1:2] : d_addr[ADDR_WIDTH+1:2];
  assign ram_wdata = d_wdata;
  assign ram_wren  = gnt[1] & d_we;

  assign i_rdata  = ram_rdata;
  assign d_rdata  = ram_rdata;
  assign i_rvalid = rst & (state_q == RD_WAIT) & (owner_q == PORT_I);
  assign d_rvalid = rst & (state_q == RD_WAIT) & (owner_q == PORT_D);

  assign unused_addr_bits = ^{i_addr[31:ADDR_WIDTH+2], i_addr[1:0],
                              d_addr[31:ADDR_WIDTH+2], d_addr[1:0]};

  always_comb begin
    state_d = IDLE;
    owner_d = owner_q;
    if (rd_grant) begin
      state_d = RD_WAIT;
      owner_d = gnt[0] ? PORT_I : PORT_D;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      owner_q  <= PORT_I;
      prefer_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      prefer_q <= prefer_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected read returns into a queue,
// a negedge monitor pops and compares them whenever an rvalid appears.
module tb_mem_arbiter;

  localparam int unsigned AW = 10;

  typedef struct packed {
    logic        port;   // 0 = I, 1 = D
    logic [31:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, d_req, d_we;
  logic [31:0]   i_addr, d_addr, d_wdata;
  logic          i_gnt, i_rvalid, d_gnt, d_rvalid, ram_wren;
  logic [31:0]   i_rdata, d_rdata, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;

  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [31:0]   pl_data;
  logic [31:0]   mem [1024];

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.WIDTH(32), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_gnt     (i_gnt),
    .i_rvalid  (i_rvalid),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_wren  (ram_wren),
    .ram_rdata (ram_rdata)
  );

  // Registered-read RAM model with a bench-only preload port.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (ram_wren) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every rvalid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (i_rvalid === 1'b1 || d_rvalid === 1'b1) begin
      exp_t e;
      chk("rvalid_onehot", {31'b0, i_rvalid & d_rvalid}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("rvalid_unexpected", {31'b0, d_rvalid}, {31'b0, ~d_rvalid});
      end else begin
        e = exp_q.pop_front();
        chk("rvalid_port", {31'b0, d_rvalid}, {31'b0, e.port});
        chk("rdata", d_rvalid ? d_rdata : i_rdata, e.data);
      end
    end
  end

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] dwd);
    @(posedge clk);
    #1;
    i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
    @(negedge clk);
  endtask

  task automatic grant(input string name, input logic eig, input logic edg, input logic ewr,
                       input logic [AW-1:0] eaddr);
    chk({name, "_i_gnt"}, {31'b0, i_gnt}, {31'b0, eig});
    chk({name, "_d_gnt"}, {31'b0, d_gnt}, {31'b0, edg});
    chk({name, "_wren"}, {31'b0, ram_wren}, {31'b0, ewr});
    if (eig | edg) chk({name, "_addr"}, {22'b0, ram_addr}, {22'b0, eaddr});
  endtask

  task automatic expect_read(input logic port, input logic [31:0] data);
    exp_t e;
    e.port = port;
    e.data = data;
    exp_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] init_vals [6];
    init_vals = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
                  32'h4444_4444, 32'h0000_0093, 32'h5555_5555};
    rst = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

    // Preload while held in reset, with both requests asserted to prove masking.
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      pl_en = 1'b1; pl_addr = AW'(k); pl_data = init_vals[k];
      i_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
    end
    @(negedge clk);
    grant("reset", 1'b0, 1'b0, 1'b0, '0);
    chk("reset_i_rvalid", {31'b0, i_rvalid}, 32'd0);
    chk("reset_d_rvalid", {31'b0, d_rvalid}, 32'd0);
    @(posedge clk);
    #1;
    pl_en = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;

    // Single fetch of word 4.
    @(posedge clk);
    #1;
    rst = 1'b1;
    i_req = 1'b1; i_addr = 32'h10;
    @(negedge clk);
    grant("fetch", 1'b1, 1'b0, 1'b0, 10'd4);
    expect_read(1'b0, 32'h0000_0093);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("fetch_i_rvalid", {31'b0, i_rvalid}, 32'd1);
    chk("fetch_d_rvalid", {31'b0, d_rvalid}, 32'd0);

    // Store then load back.
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF);
    grant("store", 1'b0, 1'b1, 1'b1, 10'd8);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
    grant("load", 1'b0, 1'b1, 1'b0, 10'd8);
    chk("store_no_rvalid", {31'b0, d_rvalid}, 32'd0);
    expect_read(1'b1, 32'hDEAD_BEEF);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("load_d_rvalid", {31'b0, d_rvalid}, 32'd1);

    // Both ports read for 4 cycles straight out of reset: I, D, I, D.
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    i_req = 1'b1; i_addr = 32'h0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4;
    @(negedge clk);
    grant("rr0", 1'b1, 1'b0, 1'b0, 10'd0);
    expect_read(1'b0, 32'h1111_1111);
    drive(1'b1, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);
    grant("rr1", 1'b0, 1'b1, 1'b0, 10'd1);
    expect_read(1'b1, 32'h2222_2222);
    drive(1'b1, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);
    grant("rr2", 1'b1, 1'b0, 1'b0, 10'd0);
    expect_read(1'b0, 32'h1111_1111);
    drive(1'b1, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);
    grant("rr3", 1'b0, 1'b1, 1'b0, 10'd1);
    expect_read(1'b1, 32'h2222_2222);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Back-to-back fetches with no bubbles.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'(4 * k), 1'b0, 1'b0, 32'h0, 32'h0);
      grant("burst", 1'b1, 1'b0, 1'b0, AW'(k));
      chk("burst_i_rvalid", {31'b0, i_rvalid}, (k == 0) ? 32'd0 : 32'd1);
      expect_read(1'b0, init_vals[k]);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("burst_tail_i_rvalid", {31'b0, i_rvalid}, 32'd1);

    // Load granted, then reset drops its rvalid; next contention goes to I.
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h14, 32'h0);
    grant("drop", 1'b0, 1'b1, 1'b0, 10'd5);
    @(posedge clk);
    #1;
    rst = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk("drop_d_rvalid", {31'b0, d_rvalid}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    i_req = 1'b1; i_addr = 32'h14; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0;
    @(negedge clk);
    chk("post_reset_d_rvalid", {31'b0, d_rvalid}, 32'd0);
    grant("post_reset", 1'b1, 1'b0, 1'b0, 10'd5);
    expect_read(1'b0, 32'h5555_5555);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
